memory_game_controller: RTL and testbench

Game-state engine for the 4x4 memory-card VGA demo. It edge-detects the five player buttons, moves the selection cursor and opens cards. It compares each opened pair, keeps matched pairs face-up and closes mismatched pairs after a fixed display delay. Its `open_cards`, `current_x` and `current_y` outputs feed the matrix pixel generator directly, so it is the producer side of that interface.

---
 rtl/memory_game_pkg.sv | 33 +++
 rtl/btn_edge_detect.sv | 27 ++
 rtl/memory_game_controller.sv | 166 ++++++++++++++++
 tb/tb_memory_game_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared types and card layout for the memory game engine
package memory_game_pkg;

  typedef enum logic [1:0] {PICK1, PICK2, SHOW, DONE} state_t;

  typedef logic [2:0] symbol_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } pos_t;

  localparam int NUM_PAIRS = 8;

  // Bit positions inside the packed button vector
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_SELECT = 4;

  localparam symbol_t CARD_SYMBOL [0:3][0:3] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd3, 3'd1, 3'd4, 3'd0},
    '{3'd5, 3'd6, 3'd6, 3'd5},
    '{3'd7, 3'd4, 3'd2, 3'd7}
  };

  function automatic symbol_t symbol_at(input pos_t p);
    return CARD_SYMBOL[p.row][p.col];
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - rising-edge press detector for the player buttons
module btn_edge_detect #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  assign prev_d = btn_in;

  // Previous sample resets high so a button held through reset cannot fire
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign press = btn_in & ~prev_q;

endmodule

// File: rtl/memory_game_controller.sv
// rtl/memory_game_controller.sv - cursor, card opening and pair matching engine
module memory_game_controller
  import memory_game_pkg::*;
#(
  parameter int MISMATCH_DELAY = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  output logic       open_cards [0:3][0:3],
  output logic [1:0] current_x,
  output logic [1:0] current_y,
  output logic [3:0] pairs_found,
  output logic [7:0] moves,
  output logic       busy,
  output logic       game_over
);

  localparam int TIMER_W = $clog2(MISMATCH_DELAY) + 1;

  state_t             state_q, state_d;
  pos_t               cursor_q, cursor_d;
  pos_t               first_q, first_d;
  pos_t               second_q, second_d;
  logic               first_v_q, first_v_d;
  logic               second_v_q, second_v_d;
  logic [0:3][0:3]    matched_q, matched_d;
  logic [3:0]         pairs_q, pairs_d;
  logic [7:0]         moves_q, moves_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [4:0]         press;
  logic               cursor_open;

  btn_edge_detect #(.WIDTH(5)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_in ({btn_select, btn_right, btn_left, btn_down, btn_up}),
    .press  (press)
  );

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        open_cards[r][c] = matched_q[r][c]
          | (first_v_q  && first_q.row  == 2'(r) && first_q.col  == 2'(c))
          | (second_v_q && second_q.row == 2'(r) && second_q.col == 2'(c));
      end
    end
  end

  assign cursor_open = open_cards[cursor_q.row][cursor_q.col];

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    first_d    = first_q;
    second_d   = second_q;
    first_v_d  = first_v_q;
    second_v_d = second_v_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    moves_d    = moves_q;
    timer_d    = timer_q;
    case (state_q)
      PICK1, PICK2: begin
        if (press[BTN_UP] && !press[BTN_DOWN]) begin
          cursor_d.row = cursor_q.row - 2'd1;
        end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
          cursor_d.row = cursor_q.row + 2'd1;
        end
        if (press[BTN_LEFT] && !press[BTN_RIGHT]) begin
          cursor_d.col = cursor_q.col - 2'd1;
        end else if (press[BTN_RIGHT] && !press[BTN_LEFT]) begin
          cursor_d.col = cursor_q.col + 2'd1;
        end
        // Select uses the pre-move cursor position
        if (press[BTN_SELECT] && !cursor_open) begin
          if (state_q == PICK1) begin
            first_d   = cursor_q;
            first_v_d = 1'b1;
            state_d   = PICK2;
          end else begin
            second_d   = cursor_q;
            second_v_d = 1'b1;
            if (moves_q != 8'hFF) begin
              moves_d = moves_q + 8'd1;
            end
            if (symbol_at(first_q) == symbol_at(cursor_q)) begin
              matched_d[first_q.row][first_q.col]   = 1'b1;
              matched_d[cursor_q.row][cursor_q.col] = 1'b1;
              first_v_d  = 1'b0;
              second_v_d = 1'b0;
              pairs_d    = pairs_q + 4'd1;
              state_d    = (pairs_q == 4'(NUM_PAIRS - 1)) ? DONE : PICK1;
            end else begin
              timer_d = TIMER_W'(MISMATCH_DELAY - 1);
              state_d = SHOW;
            end
          end
        end
      end
      SHOW: begin
        if (timer_q == '0) begin
          first_v_d  = 1'b0;
          second_v_d = 1'b0;
          state_d    = PICK1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DONE: begin
        if (press[BTN_SELECT]) begin
          state_d    = PICK1;
          cursor_d   = '0;
          first_d    = '0;
          second_d   = '0;
          first_v_d  = 1'b0;
          second_v_d = 1'b0;
          matched_d  = '0;
          pairs_d    = '0;
          moves_d    = '0;
          timer_d    = '0;
        end
      end
      default: state_d = PICK1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PICK1;
      cursor_q   <= '0;
      first_q    <= '0;
      second_q   <= '0;
      first_v_q  <= 1'b0;
      second_v_q <= 1'b0;
      matched_q  <= '0;
      pairs_q    <= '0;
      moves_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      first_q    <= first_d;
      second_q   <= second_d;
      first_v_q  <= first_v_d;
      second_v_q <= second_v_d;
      matched_q  <= matched_d;
      pairs_q    <= pairs_d;
      moves_q    <= moves_d;
      timer_q    <= timer_d;
    end
  end

  assign current_x   = cursor_q.col;
  assign current_y   = cursor_q.row;
  assign pairs_found = pairs_q;
  assign moves       = moves_q;
  assign busy        = (state_q == SHOW);
  assign game_over   = (state_q == DONE);

endmodule

// File: tb/tb_memory_game_controller.sv
// tb/tb_memory_game_controller.sv - scoreboard bench for memory_game_controller
module tb_memory_game_controller;

  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                         RT = 5'b01000, SEL = 5'b10000, NONE = 5'b00000;

  typedef struct packed {
    logic [15:0] open;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [3:0]  pairs;
    logic [7:0]  moves;
    logic        busy;
    logic        go;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
    string nm;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = RT;
  logic       open_cards [0:3][0:3];
  logic [1:0] current_x, current_y;
  logic [3:0] pairs_found;
  logic [7:0] moves;
  logic       busy, game_over;

  entry_t exp_q[$];
  snap_t  e;
  snap_t  reset_snap;
  int     cyc_cnt = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  memory_game_controller #(.MISMATCH_DELAY(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn[0]),
    .btn_down    (btn[1]),
    .btn_left    (btn[2]),
    .btn_right   (btn[3]),
    .btn_select  (btn[4]),
    .open_cards  (open_cards),
    .current_x   (current_x),
    .current_y   (current_y),
    .pairs_found (pairs_found),
    .moves       (moves),
    .busy        (busy),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    entry_t ent;
    snap_t  act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      ent = exp_q.pop_front();
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          act.open[r*4+c] = open_cards[r][c];
      act.x = current_x; act.y = current_y; act.pairs = pairs_found;
      act.moves = moves; act.busy = busy; act.go = game_over;
      n_cmp++;
      if (act !== ent.s || ent.cyc != cyc_cnt) begin
        n_bad++;
        $display("FAIL %s: got open=%h x=%0d y=%0d pairs=%0d moves=%0d busy=%b go=%b cyc=%0d, want open=%h x=%0d y=%0d pairs=%0d moves=%0d busy=%b go=%b cyc=%0d",
                 ent.nm, act.open, act.x, act.y, act.pairs, act.moves, act.busy, act.go, cyc_cnt,
                 ent.s.open, ent.s.x, ent.s.y, ent.s.pairs, ent.s.moves, ent.s.busy, ent.s.go, ent.cyc);
      end
    end
  end

  task automatic cyc(input logic [4:0] b, input string nm, input bit chk);
    entry_t ent;
    btn = b;
    if (chk) begin
      ent.s = e; ent.cyc = cyc_cnt + 1; ent.nm = nm;
      exp_q.push_back(ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b, input string nm);
    cyc(b, nm, 1'b1);
    cyc(NONE, "", 1'b0);
  endtask

  task automatic move_to(input logic [1:0] tx, input logic [1:0] ty);
    while (e.x != tx) begin
      e.x = e.x + 2'd1;
      press(RT, "nav_x");
    end
    while (e.y != ty) begin
      e.y = e.y + 2'd1;
      press(DN, "nav_y");
    end
  endtask

  task automatic match_pair(input logic [1:0] x1, input logic [1:0] y1,
                            input logic [1:0] x2, input logic [1:0] y2, input string nm);
    move_to(x1, y1);
    e.open[{y1, x1}] = 1'b1;
    press(SEL, {nm, "_a"});
    move_to(x2, y2);
    e.open[{y2, x2}] = 1'b1;
    e.moves = e.moves + 8'd1;
    e.pairs = e.pairs + 4'd1;
    if (e.pairs == 4'd8) e.go = 1'b1;
    press(SEL, {nm, "_b"});
  endtask

  initial begin
    reset_snap = '0;
    e = reset_snap;
    repeat (3) @(posedge clk);
    #1;
    cyc(RT, "reset_vals", 1'b1);
    rst = 1'b0;
    cyc(RT, "held_no_fire", 1'b1);
    cyc(NONE, "release", 1'b1);
    n_cmp++;
    if (current_x !== e.x || current_y !== e.y) begin
      n_bad++;
      $display("FAIL direct_release: x=%0d y=%0d want x=%0d y=%0d", current_x, current_y, e.x, e.y);
    end
    e.x = 2'd1; press(RT, "right_once");
    e.x = 2'd0; press(LT, "left_to_0");
    e.x = 2'd3; press(LT, "left_wrap");
    press(UP | DN, "up_down_cancel");
    e.x = 2'd0; press(RT, "right_wrap");
    n_cmp++;
    if (current_x !== e.x || current_y !== e.y) begin
      n_bad++;
      $display("FAIL direct_wrap: x=%0d y=%0d want x=%0d y=%0d", current_x, current_y, e.x, e.y);
    end
    e.open[0] = 1'b1; e.x = 2'd3; press(SEL | LT, "sel_then_left");
    e.y = 2'd1; press(DN, "down");
    e.open[7] = 1'b1; e.pairs = 4'd1; e.moves = 8'd1; press(SEL, "match_sym0");
    n_cmp++;
    if (pairs_found !== e.pairs || moves !== e.moves || open_cards[0][0] !== 1'b1 || open_cards[1][3] !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_match: pairs=%0d moves=%0d want pairs=%0d moves=%0d", pairs_found, moves, e.pairs, e.moves);
    end
    press(SEL, "sel_matched_ignored");
    e.y = 2'd0; press(UP, "up");
    e.x = 2'd0; press(RT, "right");
    e.x = 2'd1; press(RT, "right");
    e.open[1] = 1'b1; press(SEL, "pick_01");
    press(SEL, "same_card_ignored");
    e.x = 2'd0; press(LT, "left");
    press(SEL, "matched_in_pick2_ignored");
    e.x = 2'd1; press(RT, "right");
    e.x = 2'd2; press(RT, "right");
    e.open[2] = 1'b1; e.moves = 8'd2; e.busy = 1'b1;
    cyc(SEL, "mismatch_sel", 1'b1);
    n_cmp++;
    if (busy !== e.busy || moves !== e.moves || open_cards[0][1] !== 1'b1 || open_cards[0][2] !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_mismatch: busy=%b moves=%0d want busy=%b moves=%0d", busy, moves, e.busy, e.moves);
    end
    cyc(RT, "show1_ignored", 1'b1);
    cyc(NONE, "show2", 1'b1);
    cyc(LT, "show3_ignored", 1'b1);
    e.busy = 1'b0; e.open[1] = 1'b0; e.open[2] = 1'b0;
    cyc(NONE, "show_end_close", 1'b1);
    e.x = 2'd3;
    cyc(RT, "press_after_show", 1'b1);
    cyc(NONE, "", 1'b0);

    match_pair(2'd1, 2'd0, 2'd1, 2'd1, "sym1");
    match_pair(2'd2, 2'd0, 2'd2, 2'd3, "sym2");
    match_pair(2'd3, 2'd0, 2'd0, 2'd1, "sym3");
    match_pair(2'd2, 2'd1, 2'd1, 2'd3, "sym4");
    match_pair(2'd0, 2'd2, 2'd3, 2'd2, "sym5");
    match_pair(2'd1, 2'd2, 2'd2, 2'd2, "sym6");
    match_pair(2'd0, 2'd3, 2'd3, 2'd3, "sym7");
    n_cmp++;
    if (game_over !== e.go || pairs_found !== e.pairs) begin
      n_bad++;
      $display("FAIL direct_done: go=%b pairs=%0d want go=%b pairs=%0d", game_over, pairs_found, e.go, e.pairs);
    end
    press(RT, "done_move_ignored");
    e = reset_snap;
    press(SEL, "new_game");
    n_cmp++;
    if (game_over !== e.go || pairs_found !== e.pairs || moves !== e.moves ||
        current_x !== e.x || current_y !== e.y) begin
      n_bad++;
      $display("FAIL direct_new_game: go=%b pairs=%0d moves=%0d x=%0d y=%0d", game_over, pairs_found, moves, current_x, current_y);
    end

    e.open[0] = 1'b1; press(SEL, "rs_pick");
    e.x = 2'd1; press(RT, "rs_right");
    e.open[1] = 1'b1; e.moves = 8'd1; e.busy = 1'b1;
    press(SEL, "rs_mismatch");
    rst = 1'b1;
    e = reset_snap;
    cyc(NONE, "reset_mid_show", 1'b1);
    n_cmp++;
    if (busy !== e.busy || moves !== e.moves || open_cards[0][0] !== 1'b0 || open_cards[0][1] !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_reset_mid_show: busy=%b moves=%0d", busy, moves);
    end
    rst = 1'b0;
    cyc(NONE, "after_reset_idle", 1'b1);
    e.open[0] = 1'b1; press(SEL, "pick_after_reset");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      entry_t ent;
      ent = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, want cyc=%0d", ent.nm, ent.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
